// File: rtl/dp_ram_if.sv
// Port bundle for the dual-port RAM: two independent read/write ports plus
// the optional same-address dual-write flag (DPRAM_COLLISION_DET_EN).
interface dp_ram_if #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  we_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] din_a;
    logic [DATA_WIDTH-1:0] dout_a;

    logic                  we_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] din_b;
    logic [DATA_WIDTH-1:0] dout_b;

`ifdef DPRAM_COLLISION_DET_EN
    logic                  collision;
`endif

    // Requester side: drives commands, observes read data
    modport master (
        output we_a, addr_a, din_a,
        output we_b, addr_b, din_b,
`ifdef DPRAM_COLLISION_DET_EN
        input  collision,
`endif
        input  dout_a, dout_b
    );

    // RAM side: samples commands, returns registered read data
    modport slave (
        input  we_a, addr_a, din_a,
        input  we_b, addr_b, din_b,
`ifdef DPRAM_COLLISION_DET_EN
        output collision,
`endif
        output dout_a, dout_b
    );
endinterface

// File: rtl/dp_ram.sv
// True dual-port, read-first RAM with registered outputs.
// Port A wins when both ports write the same address in the same edge.
// Optional feature macro: DPRAM_COLLISION_DET_EN adds a registered
// same-address dual-write flag (bus.collision).
// Reset clears the read registers only; array contents are retained and
// writes are blocked while rst_n is low.
module dp_ram #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    dp_ram_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic same_addr_c;
    logic wr_a_c;
    logic wr_b_c;

    // Write qualification: B's write is dropped when A targets the same word
    always_comb begin
        same_addr_c = 1'b0;
        wr_a_c      = 1'b0;
        wr_b_c      = 1'b0;
        same_addr_c = (bus.addr_a == bus.addr_b);
        wr_a_c      = bus.we_a;
        wr_b_c      = bus.we_b && !(bus.we_a && same_addr_c);
    end

    // Array update; no storage reset, writes held off while in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // contents retained
        end else begin
            if (wr_b_c) begin
                mem[bus.addr_b] <= bus.din_b;
            end
            if (wr_a_c) begin
                mem[bus.addr_a] <= bus.din_a;
            end
        end
    end

    // Registered read-first outputs (old word seen on a same-edge write)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dout_a <= '0;
            bus.dout_b <= '0;
        end else begin
            bus.dout_a <= mem[bus.addr_a];
            bus.dout_b <= mem[bus.addr_b];
        end
    end

`ifdef DPRAM_COLLISION_DET_EN
    // One-cycle flag following a same-address dual write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.collision <= 1'b0;
        end else begin
            bus.collision <= bus.we_a && bus.we_b && same_addr_c;
        end
    end
`endif

endmodule

// File: tb/tb_dp_ram.sv
// Bench for dp_ram: array-level reference model checked every cycle, plus
// hand-computed expectations for the key scenarios.
module tb_dp_ram;
    localparam int unsigned AW = 6;
    localparam int unsigned DW = 8;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    dp_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dp_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Reference model: plain word array plus "written yet" flags
    logic [DW-1:0] m_mem   [DEPTH];
    bit            m_known [DEPTH];
    logic [DW-1:0] exp_a   = '0;
    logic [DW-1:0] exp_b   = '0;
    bit            exp_a_k = 1'b1;
    bit            exp_b_k = 1'b1;
    bit            exp_col = 1'b0;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_known[i] = 1'b0;
            m_mem[i]   = '0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_a = '0; exp_a_k = 1'b1;
            exp_b = '0; exp_b_k = 1'b1;
            exp_col = 1'b0;
        end else begin
            exp_a   = m_mem[bus.addr_a];
            exp_a_k = m_known[bus.addr_a];
            exp_b   = m_mem[bus.addr_b];
            exp_b_k = m_known[bus.addr_b];
            exp_col = bus.we_a && bus.we_b && (bus.addr_a == bus.addr_b);
            if (bus.we_b) begin
                m_mem[bus.addr_b] = bus.din_b; m_known[bus.addr_b] = 1'b1;
            end
            if (bus.we_a) begin
                m_mem[bus.addr_a] = bus.din_a; m_known[bus.addr_a] = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_a_k) check("model dout_a", 32'(bus.dout_a), 32'(exp_a));
            if (exp_b_k) check("model dout_b", 32'(bus.dout_b), 32'(exp_b));
`ifdef DPRAM_COLLISION_DET_EN
            check("model collision", 32'(bus.collision), 32'(exp_col));
`endif
        end
    end

    task automatic drive(input bit wa, input int aa, input int da,
                         input bit wb, input int ab, input int db);
        bus.we_a   = wa;
        bus.addr_a = AW'(aa);
        bus.din_a  = DW'(da);
        bus.we_b   = wb;
        bus.addr_b = AW'(ab);
        bus.din_b  = DW'(db);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #2;
        check("reset dout_a", 32'(bus.dout_a), 32'h0);
        check("reset dout_b", 32'(bus.dout_b), 32'h0);
        chk_en = 1'b1;
        tick(); tick();
        rst_n = 1'b1;

        // A writes 10 = AA, then reads it back
        drive(1, 10, 'hAA, 0, 0, 0); tick();
        drive(0, 10, 0, 0, 0, 0);    tick();
        check("A readback 10", 32'(bus.dout_a), 32'hAA);

        // B writes 20 = BB, then A reads 10 while B reads 20
        drive(0, 10, 0, 1, 20, 'hBB); tick();
        drive(0, 10, 0, 0, 20, 0);    tick();
        check("A read 10", 32'(bus.dout_a), 32'hAA);
        check("B read 20", 32'(bus.dout_b), 32'hBB);

        // Both read 10
        drive(0, 10, 0, 0, 10, 0); tick();
        check("shared read A", 32'(bus.dout_a), 32'hAA);
        check("shared read B", 32'(bus.dout_b), 32'hAA);

        // Same-address dual write: A wins
        drive(1, 30, 'h55, 1, 30, 'h65); tick();
`ifdef DPRAM_COLLISION_DET_EN
        check("collision set", 32'(bus.collision), 32'h1);
`endif
        drive(0, 30, 0, 0, 30, 0); tick();
        check("A priority A", 32'(bus.dout_a), 32'h55);
        check("A priority B", 32'(bus.dout_b), 32'h55);
`ifdef DPRAM_COLLISION_DET_EN
        check("collision clear", 32'(bus.collision), 32'h0);
`endif

        // A writes 11 to 10 while B reads 10: old word on both
        drive(1, 10, 'h11, 0, 10, 0); tick();
        check("cross old B", 32'(bus.dout_b), 32'hAA);
        check("read-first A", 32'(bus.dout_a), 32'hAA);
        drive(0, 10, 0, 0, 10, 0); tick();
        check("new word A", 32'(bus.dout_a), 32'h11);
        check("new word B", 32'(bus.dout_b), 32'h11);

        // Different-address dual write
        drive(1, 41, 'hC1, 1, 42, 'hC2); tick();
        drive(0, 41, 0, 0, 42, 0);       tick();
        check("dual write A", 32'(bus.dout_a), 32'hC1);
        check("dual write B", 32'(bus.dout_b), 32'hC2);

        // Fill a band of addresses through both ports, read back crossed
        for (int i = 0; i < 8; i++) begin
            drive(1, 48 + i, 3 * i + 1, 1, 56 + i, 8'hF0 - i); tick();
        end
        for (int i = 0; i < 8; i++) begin
            drive(0, 56 + i, 0, 0, 48 + i, 0); tick();
        end
        drive(0, 63, 0, 0, 48, 0); tick();
        check("band top A", 32'(bus.dout_a), 32'hE9);
        check("band low B", 32'(bus.dout_b), 32'h01);

        // Seed 40, then reset in the middle of a write to it
        drive(1, 40, 'h44, 0, 0, 0); tick();
        drive(1, 40, 'h77, 1, 40, 'h78);
        #2 rst_n = 1'b0;
        #1;
        check("async reset A", 32'(bus.dout_a), 32'h0);
        check("async reset B", 32'(bus.dout_b), 32'h0);
        tick(); tick();
        check("held reset A", 32'(bus.dout_a), 32'h0);
        drive(0, 40, 0, 0, 10, 0);
        rst_n = 1'b1;
        tick();
        check("mem 40 kept", 32'(bus.dout_a), 32'h44);
        check("mem 10 kept", 32'(bus.dout_b), 32'h11);

        // First edge after reset performs a write
        drive(1, 5, 'h5A, 0, 0, 0); tick();
        drive(0, 5, 0, 0, 5, 0);    tick();
        check("post-reset write", 32'(bus.dout_b), 32'h5A);

        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
